// File: rtl/hashcore_sched_pkg.sv
// hashcore_sched_pkg: shared widths, state type and
// helpers for the hashcore work scheduler.
package hashcore_sched_pkg;

  localparam int WORK_W  = 640;
  localparam int NONCE_W = 32;

  function automatic int core_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int NUM_CORES_DEF = 4;
  localparam int CORE_W = core_w(NUM_CORES_DEF);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_EXHAUSTED
  } sched_state_t;

endpackage

// File: rtl/hashcore_work_scheduler_if.sv
// hashcore_work_scheduler_if: host-side work offer and
// result pop handshakes of the scheduler.
interface hashcore_work_scheduler_if #(
  parameter int CORE_W = 2
);
  logic                               work_valid;
  logic                               work_ready;
  logic [hashcore_sched_pkg::WORK_W-1:0]  work_data;
  logic                               res_valid;
  logic                               res_ready;
  logic [hashcore_sched_pkg::NONCE_W-1:0] res_nonce;
  logic [CORE_W-1:0]                  res_core;

  modport master (
    output work_valid, work_data, res_ready,
    input  work_ready, res_valid, res_nonce, res_core
  );

  modport slave (
    input  work_valid, work_data, res_ready,
    output work_ready, res_valid, res_nonce, res_core
  );
endinterface

// File: rtl/sched_result_fifo.sv
// sched_result_fifo: small sync FIFO with flush; the head
// reads as zero whenever the FIFO is empty.
module sched_result_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             valid,
  output logic [WIDTH-1:0] dout
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & valid;
  assign do_push = push & (~full | do_pop);
  assign dout    = valid ? mem[rd_ptr] : '0;

  // storage, pointers and occupancy; flush empties in one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/hashcore_work_scheduler.sv
// hashcore_work_scheduler: broadcasts work units to the
// hashcore array and funnels golden-nonce hits to the host.
module hashcore_work_scheduler
  import hashcore_sched_pkg::*;
#(
  parameter int          NUM_CORES    = 4,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          LOAD_CYCLES  = 4,
  parameter logic [31:0] NONCE_BUDGET = 32'h3FFF_FFFF
) (
  input  logic                         hash_clk,
  input  logic                         reset_n,
  hashcore_work_scheduler_if.slave     host,
  output logic [WORK_W-1:0]            core_data,
  output logic [NUM_CORES-1:0]         core_load,
  input  logic [NUM_CORES-1:0]         gn_match,
  input  logic [NONCE_W*NUM_CORES-1:0] gn_nonce,
  output logic                         work_request,
  output logic                         overflow
);
  localparam int CW = core_w(NUM_CORES);
  localparam int LW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam int RW = CW + NONCE_W;
  localparam logic [LW-1:0] LOAD_LAST = LW'(LOAD_CYCLES - 1);
  localparam logic [CW-1:0] CORE_LAST = CW'(NUM_CORES - 1);
  localparam logic [31:0]   RUN_LAST  = NONCE_BUDGET - 32'd1;

  sched_state_t         state;
  sched_state_t         state_nxt;
  logic [LW-1:0]        load_cnt;
  logic [31:0]          budget_cnt;
  logic                 accept;
  logic                 running;

  logic [NUM_CORES-1:0] gn_prev;
  logic [NUM_CORES-1:0] edge_q;
  logic [NUM_CORES-1:0] pending;
  logic [NONCE_W-1:0]   pend_nonce [NUM_CORES];

  logic [CW-1:0]        rr_ptr;
  logic [CW-1:0]        grant_idx;
  logic                 grant_any;
  int                   sel;

  logic                 fifo_full;
  logic [RW-1:0]        fifo_dout;

  assign host.work_ready = (state != S_LOAD);
  assign accept          = host.work_valid & host.work_ready;
  assign running         = (state == S_RUN) | (state == S_EXHAUSTED);
  assign core_load       = {NUM_CORES{state == S_LOAD}};
  assign work_request    = (state == S_EXHAUSTED);

  // state register
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // next-state: load window, budget expiry, new work restarts
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (load_cnt == LOAD_LAST) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (accept)                      state_nxt = S_LOAD;
        else if (budget_cnt == RUN_LAST) state_nxt = S_EXHAUSTED;
      end
      S_EXHAUSTED: begin
        if (accept) state_nxt = S_LOAD;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // load window and run budget counters; budget holds once spent
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      load_cnt   <= '0;
      budget_cnt <= '0;
    end else begin
      if (accept)                load_cnt <= '0;
      else if (state == S_LOAD)  load_cnt <= load_cnt + 1'b1;
      if (state == S_LOAD)       budget_cnt <= '0;
      else if (state == S_RUN)   budget_cnt <= budget_cnt + 32'd1;
    end
  end

  // latch the broadcast work unit on accept
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n)    core_data <= '0;
    else if (accept) core_data <= host.work_data;
  end

  // rising-edge detect; only counts while cores are running
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      gn_prev <= '0;
      edge_q  <= '0;
    end else begin
      gn_prev <= gn_match;
      edge_q  <= (running && !accept) ? (gn_match & ~gn_prev) : '0;
    end
  end

  // per-core pending slot; a second hit on a full slot is lost
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      pending  <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) pend_nonce[i] <= '0;
    end else if (accept) begin
      pending <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (grant_any && grant_idx == CW'(i)) pending[i] <= 1'b0;
        if (edge_q[i]) begin
          if (pending[i]) begin
            overflow <= 1'b1;
          end else begin
            pending[i]    <= 1'b1;
            pend_nonce[i] <= gn_nonce[NONCE_W*i +: NONCE_W];
          end
        end
      end
    end
  end

  // round-robin pick starting at rr_ptr; lowest offset wins
  always_comb begin
    grant_any = 1'b0;
    grant_idx = rr_ptr;
    sel       = 0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      sel = (int'(rr_ptr) + k) % NUM_CORES;
      if (pending[sel]) begin
        grant_any = 1'b1;
        grant_idx = CW'(sel);
      end
    end
    if (fifo_full || accept) grant_any = 1'b0;
  end

  // pointer moves past the last granted core
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (grant_idx == CORE_LAST) ? '0 : grant_idx + 1'b1;
    end
  end

  sched_result_fifo #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (hash_clk),
    .rst_n (reset_n),
    .flush (accept),
    .push  (grant_any),
    .din   ({grant_idx, pend_nonce[grant_idx]}),
    .pop   (host.res_ready),
    .full  (fifo_full),
    .valid (host.res_valid),
    .dout  (fifo_dout)
  );

  assign host.res_core  = fifo_dout[RW-1 -: CW];
  assign host.res_nonce = fifo_dout[NONCE_W-1:0];

endmodule

// File: tb/tb_hashcore_work_scheduler.sv
// tb_hashcore_work_scheduler: directed scenarios plus random
// traffic against a queue-based behavioural model.
module tb_hashcore_work_scheduler;
  localparam int NC     = 4;
  localparam int DEPTH  = 8;
  localparam int LOADC  = 4;
  localparam int BUDGET = 16;

  logic         hash_clk = 1'b0;
  logic         reset_n  = 1'b0;
  logic [639:0] core_data;
  logic [3:0]   core_load;
  logic [3:0]   gn_match;
  logic [127:0] gn_nonce;
  logic         work_request;
  logic         overflow;

  hashcore_work_scheduler_if #(.CORE_W(2)) bus();

  hashcore_work_scheduler #(
    .NUM_CORES    (NC),
    .FIFO_DEPTH   (DEPTH),
    .LOAD_CYCLES  (LOADC),
    .NONCE_BUDGET (32'd16)
  ) dut (
    .hash_clk     (hash_clk),
    .reset_n      (reset_n),
    .host         (bus),
    .core_data    (core_data),
    .core_load    (core_load),
    .gn_match     (gn_match),
    .gn_nonce     (gn_nonce),
    .work_request (work_request),
    .overflow     (overflow)
  );

  always #5 hash_clk = ~hash_clk;

  int n_chk = 0;
  int n_err = 0;

  // model: 0 idle, 1 loading, 2 running, 3 budget spent
  int           ph;
  int           load_left;
  int           run_cnt;
  int           ptr;
  bit           m_prev [NC];
  bit           m_edge [NC];
  bit           m_pend [NC];
  logic [31:0]  m_pn   [NC];
  logic [33:0]  m_q    [$];
  bit           m_ovf;
  logic [639:0] m_cd;

  task automatic check(input string tag, input logic [639:0] got,
                       input logic [639:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [639:0] rand640();
    logic [639:0] r;
    for (int i = 0; i < 20; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    ph = 0; load_left = 0; run_cnt = 0; ptr = 0;
    m_ovf = 0; m_cd = '0; m_q.delete();
    for (int c = 0; c < NC; c++) begin
      m_prev[c] = 0; m_edge[c] = 0; m_pend[c] = 0; m_pn[c] = '0;
    end
  endtask

  task automatic model_step();
    bit acc;
    int g;
    bit pend0 [NC];
    bit ne [NC];
    acc = bus.work_valid && (ph != 1);
    g = -1;
    if (!acc && m_q.size() < DEPTH)
      for (int k = 0; k < NC; k++)
        if (g < 0 && m_pend[(ptr + k) % NC]) g = (ptr + k) % NC;
    for (int c = 0; c < NC; c++) begin
      ne[c] = (ph >= 2) && !acc && gn_match[c] && !m_prev[c];
      pend0[c] = m_pend[c];
    end
    if (acc) begin
      for (int c = 0; c < NC; c++) m_pend[c] = 0;
      m_q.delete();
      m_cd = bus.work_data;
    end else begin
      if (bus.res_ready && m_q.size() > 0) void'(m_q.pop_front());
      if (g >= 0) begin
        m_q.push_back({g[1:0], m_pn[g]});
        m_pend[g] = 0;
        ptr = (g + 1) % NC;
      end
      for (int c = 0; c < NC; c++)
        if (m_edge[c]) begin
          if (pend0[c]) m_ovf = 1;
          else begin
            m_pend[c] = 1;
            m_pn[c] = gn_nonce[c*32 +: 32];
          end
        end
    end
    for (int c = 0; c < NC; c++) begin
      m_prev[c] = gn_match[c];
      m_edge[c] = ne[c];
    end
    case (ph)
      0: if (acc) begin ph = 1; load_left = LOADC; end
      1: begin
        load_left--;
        if (load_left == 0) begin ph = 2; run_cnt = 0; end
      end
      2: if (acc) begin ph = 1; load_left = LOADC; end
         else begin
           run_cnt++;
           if (run_cnt == BUDGET) ph = 3;
         end
      default: if (acc) begin ph = 1; load_left = LOADC; end
    endcase
  endtask

  task automatic check_all();
    logic [33:0] head;
    head = (m_q.size() > 0) ? m_q[0] : '0;
    check("work_ready", bus.work_ready, ph != 1);
    check("core_load", core_load, (ph == 1) ? 4'hF : 4'h0);
    check("work_request", work_request, ph == 3);
    check("res_valid", bus.res_valid, m_q.size() > 0);
    check("res_nonce", bus.res_nonce, head[31:0]);
    check("res_core", bus.res_core, head[33:32]);
    check("overflow", overflow, m_ovf);
    check("core_data", core_data, m_cd);
  endtask

  task automatic tick();
    @(posedge hash_clk);
    if (!reset_n) model_reset();
    else          model_step();
    #1;
    check_all();
  endtask

  task automatic send_work(input logic [639:0] w);
    bus.work_valid = 1'b1;
    bus.work_data  = w;
    tick();
    bus.work_valid = 1'b0;
  endtask

  task automatic pulse_hit(input int c, input logic [31:0] n);
    gn_nonce[c*32 +: 32] = n;
    gn_match[c] = 1'b1;
    tick(); tick();
    gn_match[c] = 1'b0;
    tick(); tick();
  endtask

  initial begin
    logic [639:0] w;
    int cnt_load;
    int n;
    bus.work_valid = 1'b0;
    bus.work_data  = '0;
    bus.res_ready  = 1'b0;
    gn_match = '0;
    gn_nonce = '0;
    model_reset();
    #2;
    check_all();
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick();

    // work accept, load window, budget expiry
    w = rand640();
    send_work(w);
    check("t1_core_data", core_data, w);
    cnt_load = 0;
    n = 0;
    for (int i = 0; i < 40 && !work_request; i++) begin
      if (core_load == 4'hF) cnt_load++;
      tick();
      n++;
    end
    check("t1_load_len", cnt_load, LOADC);
    check("t2_req", work_request, 1'b1);
    check("t2_req_delay", n - LOADC, BUDGET);
    tick(); tick();
    send_work(rand640());
    check("t2_req_clr", work_request, 1'b0);
    for (int i = 0; i < LOADC; i++) tick();

    // simultaneous hits on cores 0 and 2
    gn_nonce[0*32 +: 32] = 32'h11;
    gn_nonce[2*32 +: 32] = 32'h22;
    gn_match = 4'b0101;
    tick(); tick();
    check("t3_lat2", bus.res_valid, 1'b0);
    tick();
    check("t3_lat3", bus.res_valid, 1'b1);
    tick();
    check("t3_core0", bus.res_core, 2'd0);
    check("t3_nonce0", bus.res_nonce, 32'h11);
    gn_match = '0;
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("t3_core2", bus.res_core, 2'd2);
    check("t3_nonce2", bus.res_nonce, 32'h22);
    bus.res_ready = 1'b1;
    tick(); tick();
    bus.res_ready = 1'b0;
    check("t3_empty", bus.res_valid, 1'b0);

    // backpressure: 10 hits into an 8-deep FIFO, then overflow
    for (int h = 0; h < 10; h++) pulse_hit(h % NC, 32'h1000 + h);
    tick(); tick();
    check("t4_ovf_pre", overflow, 1'b0);
    pulse_hit(0, 32'hBAD0);
    check("t4_ovf", overflow, 1'b1);
    bus.res_ready = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    bus.res_ready = 1'b0;
    check("t4_drained", bus.res_valid, 1'b0);

    // stale hits flushed by new work; LOAD ignores edges
    pulse_hit(1, 32'h3333);
    pulse_hit(3, 32'h4444);
    send_work(rand640());
    check("t5_flush", bus.res_valid, 1'b0);
    pulse_hit(2, 32'h5555);
    for (int i = 0; i < 10; i++) tick();
    check("t5_load_ign", bus.res_valid, 1'b0);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      bus.work_valid = ($urandom_range(0, 39) == 0);
      if (bus.work_valid) bus.work_data = rand640();
      if ((i / 200) % 2 == 1) bus.res_ready = ($urandom_range(0, 3) == 0);
      else                    bus.res_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < NC; c++)
        if ($urandom_range(0, 5) == 0) gn_match[c] = ~gn_match[c];
      for (int c = 0; c < NC; c++) gn_nonce[c*32 +: 32] = $urandom;
      tick();
    end
    bus.work_valid = 1'b0;
    bus.res_ready  = 1'b0;
    gn_match = '0;
    tick();

    // asynchronous reset mid-RUN with results queued
    send_work(rand640());
    for (int i = 0; i < LOADC; i++) tick();
    pulse_hit(3, 32'h7777);
    check("t6_pre_valid", bus.res_valid, 1'b1);
    #3;
    reset_n = 1'b0;
    #1;
    check("t6_ready", bus.work_ready, 1'b1);
    check("t6_load", core_load, 4'h0);
    check("t6_req", work_request, 1'b0);
    check("t6_valid", bus.res_valid, 1'b0);
    check("t6_nonce", bus.res_nonce, 32'h0);
    check("t6_core", bus.res_core, 2'd0);
    check("t6_ovf", overflow, 1'b0);
    check("t6_data", core_data, 640'h0);
    model_reset();
    tick();
    reset_n = 1'b1;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
